game_controller: RTL and testbench
==================================

# game_controller

Top-level sequencer for the binary-equivalent game. It fetches a range-limited random target from the LFSR source and runs the per-round countdown from a 1 Hz tick. It compares the player's switch value on submit, accumulates score and advances levels 1→2→3, ending in WIN or LOSE. It sits between the debounced key/switch inputs, the random generator and the seven-segment/LED display logic; its outputs are display-ready binary values.

## Interface
- `ROUNDS_PER_LEVEL`, default 3: correct answers needed to leave a level.
- `L1_TIME` / `L2_TIME` / `L3_TIME`, defaults 30 / 40 / 50: round time in seconds, max 63.
- `L1_PTS` / `L2_PTS` / `L3_PTS`, defaults 100 / 200 / 600: points per correct answer.
- `PENALTY`, default 5: seconds removed per wrong submit.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low.
- `sec_tick` input 1: one-cycle enable, 1 Hz.
- `start` input 1: one-cycle pulse from the debounced key.
- `submit` input 1: one-cycle pulse from the debounced key.
- `guess` input 8: switch value, unsigned.
- `rand_val` input 8: random source data.
- `rand_valid` input 1: `rand_val` valid this cycle.
- `rand_req` output 1: request for a random value.
- `target` output 8: current decimal target, binary coded.
- `time_left` output 6: seconds remaining.
- `score` output 16: accumulated score.
- `level` output 2: 1, 2 or 3; 0 in IDLE.
- `correct` output 1: one-cycle pulse.
- `wrong` output 1: one-cycle pulse.
- `win` output 1: level signal, high in WIN.
- `lose` output 1: level signal, high in LOSE.

## Operation
- Reset values: state IDLE; `target` = 0, `time_left` = 0, `score` = 0, `level` = 0; `rand_req` = 0, `correct` = 0, `wrong` = 0, `win` = 0, `lose` = 0; round count = 0.
- States: IDLE, FETCH, PLAY, WIN, LOSE.
- **IDLE:**
  - `start` → FETCH, with `level` = 1, `score` = 0, round count = 0.
- **FETCH:**
  - `rand_req` held high.
  - On a cycle with `rand_valid`, mask `rand_val` by level: L1 uses `[3:0]` and accepts ≤ 9; L2 uses `[6:0]` and accepts ≤ 99; L3 uses `[7:0]` and accepts all values.
  - Accept: load `target`, load `time_left` with the level time, drop `rand_req`, → PLAY.
  - Reject: stay in FETCH with `rand_req` high and sample again at the next `rand_valid`.
  - `sec_tick` is ignored in FETCH.
- **PLAY:**
  - `sec_tick` decrements `time_left`.
  - Correct submit (`guess == target`):
    - `correct` pulse; `score` += level points, saturating at 16'hFFFF; round count +1.
    - If round count reaches `ROUNDS_PER_LEVEL`: at L3 → WIN; otherwise `level` +1, round count = 0, → FETCH.
    - Else → FETCH at the same level.
  - Wrong submit:
    - `wrong` pulse; `time_left` −= `PENALTY`, saturating at 0.
    - If the result is 0 → LOSE; otherwise stay in PLAY.
  - Tick with `time_left` == 1 and no submit: `time_left` → 0, → LOSE.
- **WIN/LOSE:**
  - All values are held.
  - `start` → same action as `start` in IDLE.
- `start` is ignored in FETCH and PLAY; `submit` is ignored outside PLAY.
- `guess` is unsigned 8-bit; compared directly with `target`.

## Timing
- `submit` is sampled on the rising edge. `correct`/`wrong`, the score update and the next state are visible the following cycle.
- Handshake: transfer occurs only on a cycle where `rand_req` and `rand_valid` are both high.
- Minimum round turnaround after a correct submit: 1 cycle to FETCH, plus the random latency.
- `submit` and `sec_tick` in the same cycle:
  - The submit outcome takes priority.
  - A correct answer ignores the tick.
  - A wrong answer applies the penalty and the tick together, i.e. subtracts `PENALTY`+1, saturating at 0.
- `reset` asserted mid-round: asynchronous return to all reset values; any pending `rand_req` drops immediately.

## Structure
- Package `game_pkg`: state enum; level encoding constants; per-level max-target constants (9, 99, 255) and mask widths.
- Sub-module `round_timer` holds `time_left`:
  - Inputs: load, load value, tick, penalty subtract.
  - Output: zero flag.
  - Behaviour: saturating down-counter; the controller instantiates it once.

## Test plan
- Reset, then `start`; source gives `rand_val` = 8'h1C then 8'h07 → 0x0C is rejected (12 > 9) and 7 is accepted; `target` = 7, `time_left` = 30, `level` = 1.
- In PLAY with `target` = 7: `guess` = 7 plus `submit` → `correct` pulse, `score` = 100, FETCH. After 3 corrects, `level` = 2 and the next load gives `time_left` = 40.
- `time_left` = 12, `guess` = 3 ≠ `target`, `submit` → `wrong`, `time_left` = 7. With `time_left` = 4, a wrong submit → `time_left` = 0, LOSE, `lose` = 1.
- Level 3, `time_left` = 1: correct `submit` and `sec_tick` in the same cycle → `correct`, no LOSE. 9 corrects in total → `score` = 2700, `win` = 1.
- `reset` low for one cycle while FETCH holds `rand_req` high → `rand_req` = 0 immediately; all outputs at reset values; `start` restarts at `level` 1.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the binary-equivalent game sequencer.
// Holds the FSM state type, level codes and per-level target range limits.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_WIN,
        ST_LOSE
    } game_state_e;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_1    = 2'd1;
    localparam logic [1:0] LVL_2    = 2'd2;
    localparam logic [1:0] LVL_3    = 2'd3;

    localparam logic [7:0] L1_MAX = 8'd9;
    localparam logic [7:0] L2_MAX = 8'd99;
    localparam logic [7:0] L3_MAX = 8'd255;

    localparam int L1_MASK_W = 4;
    localparam int L2_MASK_W = 7;
    localparam int L3_MASK_W = 8;

    localparam logic [7:0] L1_MASK = 8'((1 << L1_MASK_W) - 1);
    localparam logic [7:0] L2_MASK = 8'((1 << L2_MASK_W) - 1);
    localparam logic [7:0] L3_MASK = 8'((1 << L3_MASK_W) - 1);

    // Narrow the raw random byte to the bit width used by a level.
    function automatic logic [7:0] mask_rand(input logic [1:0] lvl, input logic [7:0] raw);
        case (lvl)
            LVL_1:   mask_rand = raw & L1_MASK;
            LVL_2:   mask_rand = raw & L2_MASK;
            default: mask_rand = raw & L3_MASK;
        endcase
    endfunction

    function automatic logic in_range(input logic [1:0] lvl, input logic [7:0] val);
        case (lvl)
            LVL_1:   in_range = (val <= L1_MAX);
            LVL_2:   in_range = (val <= L2_MAX);
            default: in_range = (val <= L3_MAX);
        endcase
    endfunction

endpackage

// File: rtl/round_timer.sv
// Per-round seconds counter: loadable, saturating down-counter with a combined
// tick/penalty subtract. zero_next reports whether the value after this edge is 0.
module round_timer #(
    parameter int PENALTY = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [5:0] load_val,
    input  logic       tick,
    input  logic       penalty,
    output logic [5:0] time_left,
    output logic       zero_next
);

    logic [5:0] time_left_d, time_left_q;
    logic [6:0] dec;

    // A tick and a penalty in the same cycle subtract together, clamped at 0.
    always_comb begin
        dec = 7'd0;
        if (penalty) dec = 7'(PENALTY);
        if (tick)    dec = dec + 7'd1;
        if (load) begin
            time_left_d = load_val;
        end else if ({1'b0, time_left_q} > dec) begin
            time_left_d = 6'({1'b0, time_left_q} - dec);
        end else begin
            time_left_d = 6'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) time_left_q <= 6'd0;
        else        time_left_q <= time_left_d;
    end

    assign time_left = time_left_q;
    assign zero_next = (time_left_d == 6'd0);

endmodule

// File: rtl/game_controller.sv
// Game sequencer: fetches range-limited targets from the random source, runs
// the round countdown, scores submits and walks levels 1-3 to WIN or LOSE.
module game_controller
    import game_pkg::*;
#(
    parameter int ROUNDS_PER_LEVEL = 3,
    parameter int L1_TIME          = 30,
    parameter int L2_TIME          = 40,
    parameter int L3_TIME          = 50,
    parameter int L1_PTS           = 100,
    parameter int L2_PTS           = 200,
    parameter int L3_PTS           = 600,
    parameter int PENALTY          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sec_tick,
    input  logic        start,
    input  logic        submit,
    input  logic [7:0]  guess,
    input  logic [7:0]  rand_val,
    input  logic        rand_valid,
    output logic        rand_req,
    output logic [7:0]  target,
    output logic [5:0]  time_left,
    output logic [15:0] score,
    output logic [1:0]  level,
    output logic        correct,
    output logic        wrong,
    output logic        win,
    output logic        lose,
    output game_state_e state_dbg
);

    localparam logic [7:0] ROUNDS_TARGET = 8'(ROUNDS_PER_LEVEL);

    game_state_e state_d, state_q;
    logic [7:0]  target_d, target_q;
    logic [15:0] score_d, score_q;
    logic [1:0]  level_d, level_q;
    logic [7:0]  round_d, round_q;
    logic        rand_req_d, rand_req_q;
    logic        correct_d, correct_q;
    logic        wrong_d, wrong_q;
    logic        win_d, win_q;
    logic        lose_d, lose_q;

    logic        in_play, is_hit, accept;
    logic [7:0]  masked;
    logic [5:0]  level_time;
    logic [15:0] level_pts;
    logic [16:0] score_sum;
    logic [7:0]  round_inc;
    logic        timer_load, timer_tick, timer_pen, timer_zero_next;

    always_comb begin
        case (level_q)
            LVL_1:   begin level_time = 6'(L1_TIME); level_pts = 16'(L1_PTS); end
            LVL_2:   begin level_time = 6'(L2_TIME); level_pts = 16'(L2_PTS); end
            default: begin level_time = 6'(L3_TIME); level_pts = 16'(L3_PTS); end
        endcase
    end

    assign in_play   = (state_q == ST_PLAY);
    assign is_hit    = (guess == target_q);
    assign masked    = mask_rand(level_q, rand_val);
    assign accept    = (state_q == ST_FETCH) && rand_req_q && rand_valid && in_range(level_q, masked);
    assign score_sum = {1'b0, score_q} + {1'b0, level_pts};
    assign round_inc = round_q + 8'd1;

    // A correct submit swallows a coincident tick; a wrong one adds it to the penalty.
    assign timer_load = accept;
    assign timer_tick = in_play && sec_tick && !(submit && is_hit);
    assign timer_pen  = in_play && submit && !is_hit;

    round_timer #(
        .PENALTY(PENALTY)
    ) u_round_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (level_time),
        .tick     (timer_tick),
        .penalty  (timer_pen),
        .time_left(time_left),
        .zero_next(timer_zero_next)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        score_d    = score_q;
        level_d    = level_q;
        round_d    = round_q;
        rand_req_d = rand_req_q;
        correct_d  = 1'b0;
        wrong_d    = 1'b0;
        win_d      = win_q;
        lose_d     = lose_q;
        case (state_q)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    level_d    = LVL_1;
                    score_d    = 16'd0;
                    round_d    = 8'd0;
                    rand_req_d = 1'b1;
                    win_d      = 1'b0;
                    lose_d     = 1'b0;
                end
            end
            ST_FETCH: begin
                if (accept) begin
                    target_d   = masked;
                    rand_req_d = 1'b0;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (submit && is_hit) begin
                    correct_d = 1'b1;
                    score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    round_d   = round_inc;
                    if (round_inc == ROUNDS_TARGET && level_q == LVL_3) begin
                        state_d = ST_WIN;
                        win_d   = 1'b1;
                    end else begin
                        if (round_inc == ROUNDS_TARGET) begin
                            level_d = level_q + 2'd1;
                            round_d = 8'd0;
                        end
                        state_d    = ST_FETCH;
                        rand_req_d = 1'b1;
                    end
                end else if (submit) begin
                    wrong_d = 1'b1;
                    if (timer_zero_next) begin
                        state_d = ST_LOSE;
                        lose_d  = 1'b1;
                    end
                end else if (sec_tick && timer_zero_next) begin
                    state_d = ST_LOSE;
                    lose_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            target_q   <= 8'd0;
            score_q    <= 16'd0;
            level_q    <= LVL_NONE;
            round_q    <= 8'd0;
            rand_req_q <= 1'b0;
            correct_q  <= 1'b0;
            wrong_q    <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            score_q    <= score_d;
            level_q    <= level_d;
            round_q    <= round_d;
            rand_req_q <= rand_req_d;
            correct_q  <= correct_d;
            wrong_q    <= wrong_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end

    assign rand_req  = rand_req_q;
    assign target    = target_q;
    assign score     = score_q;
    assign level     = level_q;
    assign correct   = correct_q;
    assign wrong     = wrong_q;
    assign win       = win_q;
    assign lose      = lose_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed walk through the game rules, then random
// play, every cycle compared against a plain-arithmetic model of the game.
module tb_game_controller;
  import game_pkg::*;

  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_PLAY  = 2;
  localparam int PH_WIN   = 3;
  localparam int PH_LOSE  = 4;
  localparam int PEN      = 5;

  int lvl_time [4] = '{0, 30, 40, 50};
  int lvl_pts  [4] = '{0, 100, 200, 600};
  int lvl_lim  [4] = '{0, 9, 99, 255};
  int lvl_mod  [4] = '{1, 16, 128, 256};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sec_tick = 1'b0;
  logic        start = 1'b0;
  logic        submit = 1'b0;
  logic [7:0]  guess = 8'd0;
  logic [7:0]  rand_val = 8'd0;
  logic        rand_valid = 1'b0;
  logic        rand_req;
  logic [7:0]  target;
  logic [5:0]  time_left;
  logic [15:0] score;
  logic [1:0]  level;
  logic        correct;
  logic        wrong;
  logic        win;
  logic        lose;
  game_state_e state_dbg;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc_n = 0;

  // Reference model of the game
  int m_phase, m_level, m_score, m_rounds, m_target, m_time;
  bit m_correct, m_wrong, m_win, m_lose;

  game_controller dut (
    .clk       (clk),
    .reset     (reset),
    .sec_tick  (sec_tick),
    .start     (start),
    .submit    (submit),
    .guess     (guess),
    .rand_val  (rand_val),
    .rand_valid(rand_valid),
    .rand_req  (rand_req),
    .target    (target),
    .time_left (time_left),
    .score     (score),
    .level     (level),
    .correct   (correct),
    .wrong     (wrong),
    .win       (win),
    .lose      (lose),
    .state_dbg (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc_n, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_IDLE; m_level = 0; m_score = 0; m_rounds = 0;
    m_target = 0; m_time = 0;
    m_correct = 0; m_wrong = 0; m_win = 0; m_lose = 0;
  endtask

  task automatic model_step(input bit st, input bit sb, input int g, input bit tk,
                            input int rv, input bit rvld);
    int v, t;
    m_correct = 0;
    m_wrong = 0;
    case (m_phase)
      PH_IDLE, PH_WIN, PH_LOSE: begin
        if (st) begin
          m_phase = PH_FETCH; m_level = 1; m_score = 0; m_rounds = 0;
          m_win = 0; m_lose = 0;
        end
      end
      PH_FETCH: begin
        if (rvld) begin
          v = rv % lvl_mod[m_level];
          if (v <= lvl_lim[m_level]) begin
            m_target = v;
            m_time = lvl_time[m_level];
            m_phase = PH_PLAY;
          end
        end
      end
      default: begin
        if (sb && g == m_target) begin
          m_correct = 1;
          m_score = m_score + lvl_pts[m_level];
          if (m_score > 65535) m_score = 65535;
          m_rounds++;
          if (m_rounds == 3 && m_level == 3) begin
            m_phase = PH_WIN; m_win = 1;
          end else begin
            if (m_rounds == 3) begin
              m_level++; m_rounds = 0;
            end
            m_phase = PH_FETCH;
          end
        end else if (sb) begin
          m_wrong = 1;
          t = m_time - PEN - (tk ? 1 : 0);
          m_time = (t < 0) ? 0 : t;
          if (m_time == 0) begin
            m_phase = PH_LOSE; m_lose = 1;
          end
        end else if (tk) begin
          m_time--;
          if (m_time == 0) begin
            m_phase = PH_LOSE; m_lose = 1;
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("rand_req", rand_req, (m_phase == PH_FETCH) ? 1 : 0);
    check("target", target, m_target);
    check("time_left", time_left, m_time);
    check("score", score, m_score);
    check("level", level, m_level);
    check("correct", correct, m_correct);
    check("wrong", wrong, m_wrong);
    check("win", win, m_win);
    check("lose", lose, m_lose);
  endtask

  // driver: one clock cycle of inputs, then compare at the falling edge
  task automatic cyc(input bit st, input bit sb, input logic [7:0] g, input bit tk,
                     input logic [7:0] rv, input bit rvld);
    start = st; submit = sb; guess = g; sec_tick = tk; rand_val = rv; rand_valid = rvld;
    model_step(st, sb, int'(g), tk, int'(rv), rvld);
    @(posedge clk);
    #1;
    start = 0; submit = 0; sec_tick = 0; rand_valid = 0;
    cyc_n++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_start();
    cyc(1, 0, 8'd0, 0, 8'd0, 0);
  endtask

  task automatic do_tick();
    cyc(0, 0, 8'd0, 1, 8'd0, 0);
  endtask

  task automatic do_hit();
    cyc(0, 1, 8'(m_target), 0, 8'd0, 0);
  endtask

  task automatic get_target();
    for (int i = 0; i < 64 && m_phase == PH_FETCH; i++)
      cyc(0, 0, 8'd0, 0, 8'($urandom), 1);
    check("fetch_done", (m_phase == PH_PLAY) ? 1 : 0, 1);
  endtask

  initial begin
    model_reset();
    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    reset = 1'b1;
    @(negedge clk);
    compare_all();

    // first fetch: 0x1C masks to 12 (rejected), 7 accepted
    do_start();
    check("tp_level_start", level, 1);
    cyc(0, 0, 8'd0, 0, 8'h1C, 1);
    check("tp_reject_req", rand_req, 1);
    cyc(0, 0, 8'd0, 0, 8'h07, 1);
    check("tp_target7", target, 7);
    check("tp_time30", time_left, 30);

    // three corrects at L1, then a L2 load
    cyc(0, 1, 8'd7, 0, 8'd0, 0);
    check("tp_score100", score, 100);
    check("tp_correct", correct, 1);
    cyc(0, 0, 8'd0, 0, 8'h03, 1);
    do_hit();
    cyc(0, 0, 8'd0, 0, 8'h05, 1);
    do_hit();
    check("tp_level2", level, 2);
    cyc(0, 0, 8'd0, 0, 8'd50, 1);
    check("tp_time40", time_left, 40);

    // wrong submits and penalty saturation to LOSE
    repeat (28) do_tick();
    check("tp_time12", time_left, 12);
    cyc(0, 1, 8'd3, 0, 8'd0, 0);
    check("tp_wrong", wrong, 1);
    check("tp_time7", time_left, 7);
    repeat (3) do_tick();
    cyc(0, 1, 8'd3, 0, 8'd0, 0);
    check("tp_time0", time_left, 0);
    check("tp_lose", lose, 1);
    cyc(0, 1, 8'd3, 1, 8'd0, 0);
    check("tp_lose_hold", lose, 1);

    // full game to WIN; last answer coincides with the final tick
    do_start();
    for (int r = 0; r < 8; r++) begin
      get_target();
      do_hit();
    end
    get_target();
    check("tp_level3", level, 3);
    repeat (49) do_tick();
    check("tp_time1", time_left, 1);
    cyc(0, 1, 8'(m_target), 1, 8'd0, 0);
    check("tp_last_correct", correct, 1);
    check("tp_no_lose", lose, 0);
    check("tp_score2700", score, 2700);
    check("tp_win", win, 1);

    // asynchronous reset while FETCH holds rand_req
    do_start();
    check("tp_req_high", rand_req, 1);
    reset = 1'b0;
    #1;
    model_reset();
    check("tp_req_async", rand_req, 0);
    compare_all();
    @(negedge clk);
    compare_all();
    reset = 1'b1;
    do_start();
    check("tp_restart_level", level, 1);

    // random play
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 9) < 6) ? 8'(m_target) : 8'($urandom_range(0, 255)),
          ($urandom_range(0, 7) == 0),
          8'($urandom),
          1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
